jk_mux_sync_counter: RTL
========================

// Module: jk_mux_sync_counter
// PURPOSE
//  Mod-N synchronous up/down counter built from per-bit JK flip-flop cells.
//  Each cell's J/K inputs come from a 2:1-mux excitation network driven by the current count.
//  Sits directly upstream of the JK storage stage: it computes what each JK cell must see.
//  The count and terminal-count strobe feed downstream display and cascade logic.
// PARAMETERS
//  WIDTH    4   count register width in bits
//  MODULUS  10  count range 0..MODULUS-1; must satisfy 2 <= MODULUS <= 2**WIDTH
// PORTS
//  clk       in   1      rising-edge clock; the only clock
//  rst_n     in   1      reset, asynchronous, active-low
//  en        in   1      count enable; one step per clk while high
//  up_dn     in   1      1 = count up, 0 = count down
//  load      in   1      synchronous parallel load request
//  load_val  in   WIDTH  value loaded when load=1
//  q         out  WIDTH  current count (registered)
//  tc        out  1      terminal count (combinational)
//  load_err  out  1      one-cycle registered pulse: illegal load rejected
//  jk_j      out  WIDTH  J vector presented to the JK cells (debug/observe)
//  jk_k      out  WIDTH  K vector presented to the JK cells (debug/observe)
// BEHAVIOUR
//  - Reset (rst_n=0, async, no clk needed): q=0, load_err=0. tc and jk_* follow from q=0.
//    Release is synchronous to the next clk edge; the first update is on the first edge with rst_n=1.
//  - Next-state select, highest priority first:
//    1. load=1 and load_val<MODULUS: next=load_val (en ignored).
//    2. load=1 and load_val>=MODULUS: next=q (hold); load_err=1 on the following cycle.
//    3. en=1, up_dn=1: next = (q==MODULUS-1) ? 0 : q+1.
//    4. en=1, up_dn=0: next = (q==0) ? MODULUS-1 : q-1.
//    5. Otherwise: next=q.
//  - Excitation per bit i:
//    jk_j[i] = ~q[i] & next[i]; jk_k[i] = q[i] & ~next[i].
//    J=K=1 never occurs. Build it as a 2:1 mux on q[i]: sel=0 -> (J=next[i], K=0); sel=1 -> (J=0, K=~next[i]).
//  - JK cell: on rising clk, JK = 00 hold, 10 set, 01 clear, 11 toggle. Latency is 1 clk from inputs to q.
//  - tc = en & ~load & ((up_dn & q==MODULUS-1) | (~up_dn & q==0)). It is asserted in the cycle before the wrap.
//  - load_err is high for exactly one cycle per rejected load. Back-to-back illegal loads keep it high.
//  - up_dn may change on any cycle. The new direction applies at the next edge with no extra latency.
//  - Arithmetic is WIDTH bits with no carry out. Out-of-range q is unreachable except by reset, which gives 0.
//  - Mid-count reset: q goes to 0 immediately. Any pending load_err is cleared.
// STRUCTURE
//  - Shared package jk_counter_pkg: JK opcode localparams JK_HOLD=2'b00, JK_RESET=2'b01, JK_SET=2'b10, JK_TOGGLE=2'b11.
//    Also the function calc_jk(q_bit, next_bit) returning {J,K}.
//  - Sub-module jk_ff_cell: behavioural JK flip-flop with clk and async active-low rst_n.
//    Ports j, k, q, qbar. Instantiated WIDTH times via generate.
//  - Top level holds only the next-state mux chain, the excitation mux, tc, and the load_err register.
// TESTING
//  1. Reset: hold rst_n=0 mid-count at q=7, no clk edge -> q=0 and load_err=0 immediately.
//     Release -> q stays 0 until en=1.
//  2. Up wrap (defaults): en=1, up_dn=1 from 0 -> q=1..9,0.
//     tc=1 only while q=9. jk_j=4'b0000 and jk_k=4'b1001 at q=9.
//  3. Down wrap: en=1, up_dn=0 from q=0 -> q=9,8,...,0,9. tc=1 while q=0.
//     At q=0, jk_j=4'b1001.
//  4. Loads: load=1, load_val=5 with en=1 -> q=5 next cycle, no count that cycle.
//     load_val=12 at q=3 -> q=3 held, load_err=1 for one cycle, then 0.
//  5. Hold and direction: en=0 for 3 cycles -> q unchanged, jk_j=jk_k=0, tc=0.
//     Toggle up_dn every cycle at q=4 -> q=5,4,5,4.
//  6. Scoreboard: a randomised 2000-cycle run with random en/up_dn/load/load_val is compared to a reference model.
//     Checks per cycle: q always <MODULUS, J&K never both 1 on any bit, load_err only after illegal loads.

Source files
------------

// File: rtl/jk_counter_pkg.sv
// Shared definitions for the JK-cell counter: JK opcodes and the excitation mux.
package jk_counter_pkg;

  // {J,K} opcodes as seen by a JK flip-flop cell
  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Excitation for one bit, built as a 2:1 mux selected by the current bit.
  // A cell at 0 can only need a set (J=next); a cell at 1 can only need a
  // clear (K=~next). This is why J=K=1 can never be produced.
  function automatic logic [1:0] calc_jk(input logic q_bit, input logic next_bit);
    return q_bit ? {1'b0, ~next_bit} : {next_bit, 1'b0};
  endfunction

endpackage

// File: rtl/jk_ff_cell.sv
// Behavioural JK flip-flop with asynchronous active-low reset.
module jk_ff_cell
  import jk_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q,
  output logic qbar
);

  // JK storage: hold / set / clear / toggle on the rising edge
  // NOTE: sequential state uses non-blocking (<=) so every cell samples the
  // pre-edge values of its neighbours, exactly like real flip-flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        JK_HOLD:  q <= q;
        JK_SET:   q <= 1'b1;
        JK_RESET: q <= 1'b0;
        default:  q <= ~q;
      endcase
    end
  end

  assign qbar = ~q;

endmodule

// File: rtl/jk_mux_sync_counter.sv
// Mod-MODULUS synchronous up/down counter with parallel load, built from
// per-bit JK cells driven by a 2:1-mux excitation network.
module jk_mux_sync_counter
  import jk_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             load_err,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k
);

  localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2**WIDTH is representable for the load check
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] qbar;
  logic             illegal_load;
  logic             q_is_zero;
  logic             q_is_max;

  assign q_is_zero = &qbar;
  assign q_is_max  = (q == Q_MAX);

  // Next-state select: legal load, rejected load (hold), count up, count down, hold
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    q_next       = q;
    illegal_load = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        q_next = load_val;
      end else begin
        illegal_load = 1'b1;
      end
    end else if (en) begin
      if (up_dn) begin
        q_next = q_is_max ? '0 : q + 1'b1;
      end else begin
        q_next = q_is_zero ? Q_MAX : q - 1'b1;
      end
    end
  end

  // Per-bit excitation mux feeding one JK cell each
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign {jk_j[i], jk_k[i]} = calc_jk(q[i], q_next[i]);

    jk_ff_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .j     (jk_j[i]),
      .k     (jk_k[i]),
      .q     (q[i]),
      .qbar  (qbar[i])
    );
  end

  // Terminal count: high in the cycle before a wrap in the current direction
  assign tc = en & ~load & ((up_dn & q_is_max) | (~up_dn & q_is_zero));

  // Rejected-load flag, one cycle after each illegal load request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_err <= 1'b0;
    end else begin
      load_err <= illegal_load;
    end
  end

endmodule
